// File: rtl/keyscan_pkg.sv
// rtl/keyscan_pkg.sv - shared state encoding and counter widths for the keypad encoder
package keyscan_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    localparam int DCNT_W = 8;
    localparam int RCNT_W = 32;

endpackage

// File: rtl/keyscan_prienc.sv
// rtl/keyscan_prienc.sv - combinational highest-index key encoder with any/multi flags
module keyscan_prienc #(
    parameter int NKEYS = 20,
    localparam int CW = $clog2(NKEYS)
) (
    input  logic [NKEYS-1:0] vec,
    output logic [CW-1:0]    code,
    output logic             any,
    output logic             multi
);

    int unsigned nset;

    always_comb begin
        code = '0;
        nset = 0;
        for (int i = 0; i < NKEYS; i++) begin
            if (vec[i]) begin
                code = CW'(i);
                nset = nset + 1;
            end
        end
        any   = (nset != 0);
        multi = (nset > 1);
    end

endmodule

// File: rtl/keyscan_enc.sv
// rtl/keyscan_enc.sv - synchronise, debounce and priority-encode a key vector
// Emits registered press/repeat and release strobes.
module keyscan_enc
    import keyscan_pkg::*;
#(
    parameter int NKEYS         = 20,
    parameter int DEBOUNCE      = 2,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    localparam int CW = $clog2(NKEYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] in,
    input  logic             repeat_en,
    output logic             strobe,
    output logic             release_strobe,
    output logic [CW-1:0]    out,
    output logic             multi
);

    localparam logic [DCNT_W-1:0] DB_LIM = DCNT_W'(DEBOUNCE);
    localparam logic [RCNT_W-1:0] RDLY   = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] RPER   = RCNT_W'(REPEAT_PERIOD);

    logic [NKEYS-1:0]  sync1_q, sync2_q;
    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic              rep_first_q, rep_first_d;
    logic [CW-1:0]     cand_q, cand_d;
    logic              strobe_q, strobe_d;
    logic              rel_q, rel_d;
    logic [CW-1:0]     out_q, out_d;
    logic              multi_q, multi_d;

    logic [CW-1:0]     code_c;
    logic              any_c;
    logic              multi_c;

    keyscan_prienc #(.NKEYS(NKEYS)) u_prienc (
        .vec   (sync2_q),
        .code  (code_c),
        .any   (any_c),
        .multi (multi_c)
    );

    assign rcnt_inc = rcnt_q + RCNT_W'(1);

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        rcnt_d      = rcnt_q;
        rep_first_d = rep_first_q;
        cand_d      = cand_q;
        strobe_d    = 1'b0;
        rel_d       = 1'b0;
        out_d       = out_q;
        multi_d     = multi_q;
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    cand_d = code_c;
                    dcnt_d = DCNT_W'(1);
                    if (DEBOUNCE == 1) begin
                        state_d     = HELD;
                        strobe_d    = 1'b1;
                        out_d       = code_c;
                        multi_d     = multi_c;
                        rcnt_d      = '0;
                        rep_first_d = 1'b1;
                    end else begin
                        state_d = DB_PRESS;
                    end
                end
            end
            DB_PRESS: begin
                if (!any_c) begin
                    state_d = IDLE;
                end else if (code_c != cand_q) begin
                    cand_d = code_c;
                    dcnt_d = DCNT_W'(1);
                end else if (dcnt_q >= DB_LIM) begin
                    state_d     = HELD;
                    strobe_d    = 1'b1;
                    out_d       = cand_q;
                    multi_d     = multi_c;
                    rcnt_d      = '0;
                    rep_first_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            HELD: begin
                // Key changes while held are ignored: only full release matters.
                if (!any_c) begin
                    if (DEBOUNCE == 1) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        state_d = DB_REL;
                        dcnt_d  = DCNT_W'(1);
                    end
                end else if (repeat_en) begin
                    if (rcnt_inc == (rep_first_q ? RDLY : RPER)) begin
                        strobe_d    = 1'b1;
                        rcnt_d      = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        rcnt_d = rcnt_inc;
                    end
                end else begin
                    rcnt_d = '0;
                end
            end
            DB_REL: begin
                if (any_c) begin
                    state_d = HELD;
                end else if (dcnt_q >= DB_LIM) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= IDLE;
            dcnt_q      <= '0;
            rcnt_q      <= '0;
            rep_first_q <= 1'b1;
            cand_q      <= '0;
            strobe_q    <= 1'b0;
            rel_q       <= 1'b0;
            out_q       <= '0;
            multi_q     <= 1'b0;
        end else begin
            sync1_q     <= in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            rcnt_q      <= rcnt_d;
            rep_first_q <= rep_first_d;
            cand_q      <= cand_d;
            strobe_q    <= strobe_d;
            rel_q       <= rel_d;
            out_q       <= out_d;
            multi_q     <= multi_d;
        end
    end

    assign strobe         = strobe_q;
    assign release_strobe = rel_q;
    assign out            = out_q;
    assign multi          = multi_q;

endmodule

// File: tb/tb_keyscan_enc.sv
// tb/tb_keyscan_enc.sv - scoreboard bench for keyscan_enc
module tb_keyscan_enc;

    localparam int NKEYS = 20;
    localparam int DEB   = 2;
    localparam int RDLY  = 10;
    localparam int RPER  = 4;
    localparam int CW    = $clog2(NKEYS);

    typedef struct {
        int            cyc;
        bit            rel;
        logic [CW-1:0] code;
        logic          mul;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NKEYS-1:0] in_v = '0;
    logic             repeat_en = 1'b0;
    logic             strobe_o, rel_o, multi_o;
    logic [CW-1:0]    out_o;

    ev_t exp_q[$];
    int  cyc = 0;
    int  tests_run = 0;
    int  fails = 0;

    keyscan_enc #(
        .NKEYS(NKEYS), .DEBOUNCE(DEB), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in             (in_v),
        .repeat_en      (repeat_en),
        .strobe         (strobe_o),
        .release_strobe (rel_o),
        .out            (out_o),
        .multi          (multi_o)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        ev_t e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (strobe_o || rel_o) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event cyc=%0d strobe=%b release=%b out=%0d, required no event",
                             cyc, strobe_o, rel_o, out_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || rel_o !== e.rel || strobe_o === rel_o ||
                        out_o !== e.code || multi_o !== e.mul) begin
                        fails++;
                        $display("FAIL event got cyc=%0d strobe=%b rel=%b out=%0d multi=%b, required cyc=%0d rel=%b out=%0d multi=%b",
                                 cyc, strobe_o, rel_o, out_o, multi_o, e.cyc, e.rel, e.code, e.mul);
                    end
                end
            end
        end
    end

    task automatic push(input int at, input bit rel, input int code, input logic mul);
        ev_t e;
        e.cyc = at; e.rel = rel; e.code = CW'(code); e.mul = mul;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive at a negedge; the following posedge (cyc+1) is edge 0.
    task automatic drive(input logic [NKEYS-1:0] v);
        @(negedge clk);
        in_v = v;
    endtask

    task automatic check_drained(input string name);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s missing_events pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_outs_zero(input string name);
        tests_run++;
        if (strobe_o !== 1'b0 || rel_o !== 1'b0 || out_o !== '0 || multi_o !== 1'b0) begin
            fails++;
            $display("FAIL %s outputs strobe=%b rel=%b out=%0d multi=%b, required all 0",
                     name, strobe_o, rel_o, out_o, multi_o);
        end
    endtask

    task automatic test_reset();
        in_v  = '1;
        rst_n = 1'b0;
        wait_cycles(3);
        #1;
        check_outs_zero("reset_hold");
        rst_n = 1'b1;
        push(cyc + 1 + DEB + 2, 1'b0, NKEYS - 1, 1'b1);
        wait_cycles(9);
        drive('0);
        push(cyc + 1 + DEB + 2, 1'b1, NKEYS - 1, 1'b1);
        wait_cycles(8);
        check_drained("reset");
    endtask

    task automatic test_single();
        logic [NKEYS-1:0] v;
        v = '0; v[7] = 1'b1;
        drive(v);
        push(cyc + 1 + DEB + 2, 1'b0, 7, 1'b0);
        wait_cycles(8);
        drive('0);
        push(cyc + 1 + DEB + 2, 1'b1, 7, 1'b0);
        wait_cycles(8);
        check_drained("single");
    endtask

    task automatic test_glitch();
        logic [NKEYS-1:0] v3, v5;
        v3 = '0; v3[3] = 1'b1;
        v5 = '0; v5[5] = 1'b1;
        drive(v3);
        drive('0);
        wait_cycles(8);
        check_drained("glitch");
        drive(v3);
        drive(v5);
        push(cyc + 1 + DEB + 2, 1'b0, 5, 1'b0);
        wait_cycles(8);
        drive('0);
        push(cyc + 1 + DEB + 2, 1'b1, 5, 1'b0);
        wait_cycles(8);
        check_drained("restart");
    endtask

    task automatic test_multi();
        logic [NKEYS-1:0] v;
        v = '0; v[2] = 1'b1; v[9] = 1'b1;
        drive(v);
        push(cyc + 1 + DEB + 2, 1'b0, 9, 1'b1);
        wait_cycles(8);
        v[12] = 1'b1;
        drive(v);
        wait_cycles(8);
        check_drained("multi_no_rollover");
        drive('0);
        push(cyc + 1 + DEB + 2, 1'b1, 9, 1'b1);
        wait_cycles(8);
        check_drained("multi_release");
    endtask

    task automatic test_repeat();
        logic [NKEYS-1:0] v;
        int p;
        v = '0; v[0] = 1'b1;
        repeat_en = 1'b1;
        drive(v);
        p = cyc + 1 + DEB + 2;
        push(p, 1'b0, 0, 1'b0);
        push(p + RDLY, 1'b0, 0, 1'b0);
        push(p + RDLY + RPER, 1'b0, 0, 1'b0);
        push(p + RDLY + 2 * RPER, 1'b0, 0, 1'b0);
        while (cyc < p + RDLY + 2 * RPER + 1) @(negedge clk);
        repeat_en = 1'b0;
        wait_cycles(20);
        check_drained("repeat");
        drive('0);
        push(cyc + 1 + DEB + 2, 1'b1, 0, 1'b0);
        wait_cycles(8);
        check_drained("repeat_release");
    endtask

    task automatic test_reset_mid();
        logic [NKEYS-1:0] v;
        v = '0; v[4] = 1'b1;
        drive(v);
        push(cyc + 1 + DEB + 2, 1'b0, 4, 1'b0);
        wait_cycles(8);
        check_drained("pre_mid_reset");
        tests_run++;
        if (out_o !== CW'(4)) begin
            fails++;
            $display("FAIL held_out out=%0d required 4", out_o);
        end
        rst_n = 1'b0;
        in_v  = '0;
        #1;
        check_outs_zero("reset_mid_held");
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(10);
        check_drained("no_release_after_reset");
        v = '0; v[6] = 1'b1;
        drive(v);
        wait_cycles(2);
        rst_n = 1'b0;
        in_v  = '0;
        #1;
        check_outs_zero("reset_mid_dbpress");
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(10);
        check_drained("no_event_after_dbpress_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_multi();
        test_repeat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/keyscan_enc.md
# keyscan_enc

Parametrised keypad scanner/encoder: synchronises an N-bit one-hot-ish key vector, debounces it, priority-encodes the winning key, and emits registered press/release strobes with optional auto-repeat. Sits between the drum-pad input pins and the pattern sequencer/sample-trigger logic, replacing the fixed 20-key encoder that had no debounce, no release event and undefined multi-key codes.

## Interface
- NKEYS, 20: number of key inputs (2..64)
- DEBOUNCE, 2: consecutive identical samples required to accept a press or release (1..255)
- REPEAT_DELAY, 50_000_000: cycles from press strobe to first auto-repeat strobe (≥1)
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat strobes (≥1)
- CW (localparam): $clog2(NKEYS)
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- in  in  NKEYS  raw key levels, asynchronous, 1 = pressed
- repeat_en  in  1  enables auto-repeat while a key is held
- strobe  out  1  one-cycle pulse: key accepted (press or repeat)
- release_strobe  out  1  one-cycle pulse: held key released
- out  out  CW  code of accepted key; held until next press strobe
- multi  out  1  more than one key was set at the accepting sample; updated with strobe

## Operation
- in passes through a 2-flop synchroniser → s. code_c = highest set index of s; any_c = |s.
- FSM states IDLE, DB_PRESS, HELD, DB_REL; debounce counter dcnt (8 bits), repeat counter rcnt (32 bits), candidate cand.
- IDLE: any_c → DB_PRESS, cand=code_c, dcnt=1. If DEBOUNCE=1, go straight to HELD and strobe.
- DB_PRESS: !any_c → IDLE. code_c≠cand → cand=code_c, dcnt=1 (restart). Else dcnt++; when dcnt reaches DEBOUNCE → HELD, strobe=1, out=cand, multi=(popcount(s)>1), rcnt=0.
- HELD: !any_c → DB_REL, dcnt=1 (DEBOUNCE=1: straight to IDLE with release_strobe). Any other key change while held is ignored (no rollover). With repeat_en: rcnt++; at rcnt=REPEAT_DELAY (first) or REPEAT_PERIOD (later) strobe=1, rcnt=0; out/multi unchanged. repeat_en low: rcnt held at 0.
- DB_REL: any_c → HELD (no new strobe, rcnt continues). Else dcnt++; at DEBOUNCE → IDLE, release_strobe=1.
- strobe and release_strobe never both high; all outputs registered.

## Timing
- Reset (rst_n low, any time, incl. mid-debounce or mid-repeat): state IDLE, synchroniser 0, strobe=0, release_strobe=0, out=0, multi=0, counters 0. No pulse on reset release.
- Press latency: in stable high before edge 0 → strobe high for the cycle after edge DEBOUNCE+2 (DEBOUNCE=2: after edge 4).
- Release latency: in low before edge 0 → release_strobe high the cycle after edge DEBOUNCE+2.
- Glitch shorter than DEBOUNCE samples: no strobe, FSM returns to IDLE/HELD.
- Auto-repeat: first repeat strobe REPEAT_DELAY cycles after press strobe, then every REPEAT_PERIOD cycles; repeat_en dropping mid-count clears rcnt, no strobe.
- Counters saturate/never wrap: dcnt stops at DEBOUNCE; rcnt reset at each repeat.

## Structure
- Package keyscan_pkg: state enum (IDLE, DB_PRESS, HELD, DB_REL), counter width constants.
- One sub-module: keyscan_prienc #(NKEYS) — combinational highest-index encoder producing code, any, multi.
- Synchroniser and FSM inline in keyscan_enc.

## Test plan
- Reset: rst_n low 3 cycles with in=all-ones → all outputs 0; release → first strobe exactly DEBOUNCE+2 edges after reset deassertion sample, out=NKEYS-1.
- Single press key 7, DEBOUNCE=2 → one strobe after edge 4, out=7, multi=0; release → one release_strobe after edge 4.
- 1-cycle glitch on key 3 → no strobe; key 3 then key 5 before acceptance → debounce restarts, strobe with out=5.
- Keys 2 and 9 together → out=9, multi=1; key 12 added while held → no new strobe.
- repeat_en=1, REPEAT_DELAY=10, REPEAT_PERIOD=4, hold key 0 → strobes at press, +10, +14, +18; drop repeat_en → strobes stop.
- rst_n asserted mid-DB_PRESS and mid-HELD → outputs 0 immediately, no release_strobe after reset release while in=0.
